// File: rtl/store_unit_pkg.sv
// Shared refcpu store-path definitions: op encodings, bus sizes and the store FSM states.
package store_unit_pkg;

  typedef enum logic [1:0] {
    ST_B   = 2'd0,
    ST_H   = 2'd1,
    ST_W   = 2'd2,
    ST_RSV = 2'd3
  } store_op_t;

  typedef enum logic [2:0] {
    MSIZE_1B = 3'd0,
    MSIZE_2B = 3'd1,
    MSIZE_4B = 3'd2
  } msize_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4,
    TOUT  = 3'd5
  } store_state_t;

endpackage

// File: rtl/store_unit_format.sv
// Combinational store formatting: bus size, byte strobes, lane-replicated data, misalignment.
module store_unit_format
  import store_unit_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [2:0]  size,
  output logic [3:0]  strobe,
  output logic [31:0] lane_data,
  output logic        misaligned
);

  always_comb begin
    size       = MSIZE_1B;
    strobe     = 4'b0000;
    lane_data  = 32'd0;
    misaligned = 1'b0;
    case (store_op_t'(op))
      ST_B: begin
        size      = MSIZE_1B;
        strobe    = 4'b0001 << addr_lo;
        lane_data = {4{data[7:0]}};
      end
      ST_H: begin
        size       = MSIZE_2B;
        strobe     = 4'b0011 << {addr_lo[1], 1'b0};
        lane_data  = {2{data[15:0]}};
        misaligned = addr_lo[0];
      end
      ST_W: begin
        size       = MSIZE_4B;
        strobe     = 4'b1111;
        lane_data  = data;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        // Reserved op is reported as an address-error store, same as misalignment.
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Single-request store unit: formats one SB/SH/SW, runs the addr_ok/data_ok handshake,
// and reports done, alignment fault or watchdog timeout to the memory stage.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  output logic        done,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic        timeout
);

  localparam logic [31:0] TLIM = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  store_state_t state_reg;
  logic [31:0]  counter_reg;

  logic [2:0]  fmt_size;
  logic [3:0]  fmt_strobe;
  logic [31:0] fmt_data;
  logic        fmt_misaligned;
  logic        tout_hit;

  store_unit_format u_format (
    .op         (in_op),
    .addr_lo    (in_addr[1:0]),
    .data       (in_data),
    .size       (fmt_size),
    .strobe     (fmt_strobe),
    .lane_data  (fmt_data),
    .misaligned (fmt_misaligned)
  );

  assign in_ready = (state_reg == IDLE) && !reset;
  assign tout_hit = (TIMEOUT != 0) && (counter_reg == TLIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      counter_reg <= 32'd0;
      dreq_valid  <= 1'b0;
      dreq_addr   <= 32'd0;
      dreq_size   <= 3'd0;
      dreq_strobe <= 4'd0;
      dreq_data   <= 32'd0;
      done        <= 1'b0;
      fault       <= 1'b0;
      fault_addr  <= 32'd0;
      timeout     <= 1'b0;
    end else begin
      done    <= 1'b0;
      fault   <= 1'b0;
      timeout <= 1'b0;
      // Counter only advances while a bus transaction is outstanding; it sticks at all-ones.
      if ((state_reg == REQ || state_reg == WAIT) && counter_reg != 32'hFFFF_FFFF) begin
        counter_reg <= counter_reg + 32'd1;
      end
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            counter_reg <= 32'd0;
            if (fmt_misaligned) begin
              state_reg  <= FAULT;
              fault      <= 1'b1;
              fault_addr <= in_addr;
            end else begin
              state_reg   <= REQ;
              dreq_valid  <= 1'b1;
              dreq_addr   <= in_addr;
              dreq_size   <= fmt_size;
              dreq_strobe <= fmt_strobe;
              dreq_data   <= fmt_data;
            end
          end
        end
        REQ: begin
          // A completing handshake beats the watchdog; data_ok alone is ignored here.
          if (dresp_addr_ok && dresp_data_ok) begin
            state_reg  <= DONE;
            done       <= 1'b1;
            dreq_valid <= 1'b0;
          end else if (tout_hit) begin
            state_reg  <= TOUT;
            timeout    <= 1'b1;
            dreq_valid <= 1'b0;
          end else if (dresp_addr_ok) begin
            state_reg  <= WAIT;
            dreq_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (dresp_data_ok) begin
            state_reg <= DONE;
            done      <= 1'b1;
          end else if (tout_hit) begin
            state_reg <= TOUT;
            timeout   <= 1'b1;
          end
        end
        DONE, FAULT, TOUT: state_reg <= IDLE;
        default:           state_reg <= IDLE;
      endcase
    end
  end

endmodule
